// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder slice with a registered carry, LSB first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] opa, opb, acc;
   logic [CW-1:0]    cnt;
   logic             c, h1s, h1c, s, cn, last;
   // full-adder slice built from two half adders and an OR
   always_comb begin
      h1s  = opa[0] ^ opb[0];
      h1c  = opa[0] & opb[0];
      s    = h1s ^ c;
      cn   = h1c | (h1s & c);
      last = cnt == CW'(WIDTH - 1);
   end
   // control FSM, operand shifters, carry and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         cnt   <= '0;
         c     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opa   <= a;
               opb   <= b;
               c     <= 1'b0;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               acc <= {s, acc[WIDTH-1:1]};
               opa <= opa >> 1;
               opb <= opb >> 1;
               c   <= cn;
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  sum   <= {s, acc[WIDTH-1:1]};
                  cout  <= cn;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
   localparam int W = 8;
   logic clk = 1'b0, rst_n, start;
   logic [W-1:0] a, b, sum;
   logic busy, done, cout;
   logic [1:0] a2, b2, sum2;
   logic busy2, done2, cout2;
   logic [15:0] a16, b16, sum16;
   logic busy16, done16, cout16;
   int checks = 0, errs = 0, lat;
   bit cmp_en = 0;
   logic m_busy = 0, m_done = 0, m_cout = 0;
   logic [W-1:0] m_sum = '0;
   logic [W:0] m_res = '0;
   int m_left = 0, m_ops = 0;
   logic [2:0] e2 = '0;
   logic [16:0] e16 = '0;
   logic d2p = 0, d16p = 0;

   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout));
   serial_adder #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));
   serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(start), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: a result a+b appears WIDTH cycles after acceptance, for one cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_left = 0;
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1;
            {m_cout, m_sum} = m_res;
         end
      end else if (start) begin
         m_busy = 1; m_left = W; m_res = {1'b0, a} + {1'b0, b}; m_ops++;
      end
   end

   // expected results for the narrow and wide instances
   always @(posedge clk) begin
      if (rst_n && !busy2 && start) e2 <= {1'b0, a2} + {1'b0, b2};
      if (rst_n && !busy16 && start) e16 <= {1'b0, a16} + {1'b0, b16};
   end

   // per-cycle comparison against the model
   always @(negedge clk) if (cmp_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
      if (done2) chk("w2_result", {cout2, sum2}, e2);
      if (d2p) chk("w2_done_width", done2, 1'b0);
      if (done16) chk("w16_result", {cout16, sum16}, e16);
      if (d16p) chk("w16_done_width", done16, 1'b0);
      d2p = done2;
      d16p = done16;
   end

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (!done) begin
         checks++; errs++;
         $display("FAIL done_timeout: got no done after %0d cycles required done", n);
      end
   endtask

   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x; b = y; start = 1;
      @(negedge clk);
      start = 0;
      wait_done(lat);
   endtask

   initial begin
      rst_n = 0; start = 0; a = '0; b = '0;
      a2 = '0; b2 = '0; a16 = '0; b16 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, 8'h00);
      chk("rst_cout", cout, 1'b0);
      cmp_en = 1;
      rst_n = 1;
      op(8'd3, 8'd5);
      chk("t1_latency", lat, W);
      chk("t1_sum", sum, 8'd8);
      chk("t1_cout", cout, 1'b0);
      @(negedge clk);
      chk("t1_done_drop", done, 1'b0);
      chk("t1_sum_hold", sum, 8'd8);
      op(8'hFF, 8'h01);
      chk("t2a", {cout, sum}, 9'h100);
      op(8'hFF, 8'hFF);
      chk("t2b", {cout, sum}, 9'h1FE);
      @(negedge clk);
      a = 8'h0F; b = 8'h01; start = 1;
      @(negedge clk);
      a = 8'h20; b = 8'h22;
      wait_done(lat);
      chk("t3_sum", sum, 8'h10);
      @(negedge clk);
      chk("t3_idle_gap", busy, 1'b0);
      @(negedge clk);
      chk("t3_reaccept", busy, 1'b1);
      start = 0;
      wait_done(lat);
      chk("t3_second", sum, 8'h42);
      @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1;
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      a = 8'hAA; start = 1;
      @(negedge clk);
      start = 0;
      chk("t4_hold", sum, 8'h42);
      wait_done(lat);
      chk("t4_sum", sum, 8'h33);
      @(negedge clk);
      @(negedge clk);
      a = 8'h55; b = 8'h0F; start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("t5_busy", busy, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_sum", sum, 8'h00);
      chk("t5_cout", cout, 1'b0);
      @(negedge clk);
      rst_n = 1;
      op(8'd1, 8'd1);
      chk("t5_fresh", {cout, sum}, 9'd2);
      for (int i = 0; i < 30000 && m_ops < 1030; i++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom);
         a2 = 2'($urandom); b2 = 2'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         start = $urandom_range(0, 3) != 0;
      end
      start = 0;
      repeat (W + 4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
